mem_port_arbiter: RTL and testbench

Shares the single-ported unified memory between the instruction-fetch path and the load/store path driven by the control unit's read/write/width signals. Fixed data-over-fetch priority with a fetch anti-starvation counter, one outstanding access at a time. Performs byte-lane alignment, byte enables, load sign/zero extension and misalignment detection. Sits between the pipeline front-end/MEM stage and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 43 ++++
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_lane_align.sv | 69 ++++++
 rtl/mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Holds the funct3-style width codes, the sign and direction bits, the latched
// access descriptor and the base byte-enable helper.
package mem_port_arbiter_pkg;

  // Access size field, dm_width_in[1:0]
  localparam logic [1:0] MEM_WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] MEM_WIDTH_HALF  = 2'b01;
  localparam logic [1:0] MEM_WIDTH_WORD  = 2'b10;
  localparam logic [1:0] MEM_WIDTH_DWORD = 2'b11;

  // Extension bit, dm_width_in[2]
  localparam logic MEM_SIGN   = 1'b0;
  localparam logic MEM_UNSIGN = 1'b1;

  // Access direction
  localparam logic MEM_LOAD  = 1'b0;
  localparam logic MEM_STORE = 1'b1;

  // A fetch is handled as an unsigned word load, so the same lane logic picks
  // the correct half of the doubleword.
  localparam logic [2:0] MEM_WIDTH_FETCH = {MEM_UNSIGN, MEM_WIDTH_WORD};

  // Descriptor of the access currently owning the memory port
  typedef struct packed {
    logic       fetch;
    logic       we;
    logic [2:0] width;
  } acc_ctl_t;

  // Byte enables of an access at lane 0
  function automatic logic [7:0] mem_be_base(input logic [1:0] size);
    logic [7:0] be;
    case (size)
      MEM_WIDTH_BYTE: be = 8'h01;
      MEM_WIDTH_HALF: be = 8'h03;
      MEM_WIDTH_WORD: be = 8'h0F;
      default:        be = 8'hFF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
// slave  : the arbiter's view (requests and memory responses in, grants,
//          completions and memory requests out).
// master : the surrounding pipeline + memory model's view.
interface mem_port_arbiter_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
);

  // Instruction fetch path
  logic              if_req_in;
  logic [ADDR_W-1:0] if_addr_in;
  logic              if_gnt_out;
  logic              if_done_out;
  logic [31:0]       if_rdata_out;
  logic              if_err_out;

  // Load/store path
  logic              dm_req_in;
  logic              dm_we_in;
  logic [ADDR_W-1:0] dm_addr_in;
  logic [2:0]        dm_width_in;
  logic [XLEN-1:0]   dm_wdata_in;
  logic              dm_gnt_out;
  logic              dm_done_out;
  logic [XLEN-1:0]   dm_rdata_out;
  logic              dm_err_out;

  // Memory side
  logic              mem_req_out;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [7:0]        mem_be_out;
  logic [XLEN-1:0]   mem_wdata_out;
  logic              mem_ready_in;
  logic [XLEN-1:0]   mem_rdata_in;

  modport slave (
    input  if_req_in, if_addr_in,
    output if_gnt_out, if_done_out, if_rdata_out, if_err_out,
    input  dm_req_in, dm_we_in, dm_addr_in, dm_width_in, dm_wdata_in,
    output dm_gnt_out, dm_done_out, dm_rdata_out, dm_err_out,
    output mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out,
    input  mem_ready_in, mem_rdata_in
  );

  modport master (
    output if_req_in, if_addr_in,
    input  if_gnt_out, if_done_out, if_rdata_out, if_err_out,
    output dm_req_in, dm_we_in, dm_addr_in, dm_width_in, dm_wdata_in,
    input  dm_gnt_out, dm_done_out, dm_rdata_out, dm_err_out,
    input  mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out,
    output mem_ready_in, mem_rdata_in
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for one access on an 8-byte memory word.
// Ports:
//   addr_lo    : byte offset within the doubleword
//   width      : funct3 size/extension code
//   is_fetch   : fetch access (all lanes enabled)
//   wdata      : LSB-justified store data
//   rdata      : aligned doubleword from memory
//   be_c       : byte enables
//   wdata_c    : store data shifted onto its lanes
//   rdata_c    : extracted, sign/zero-extended load result
//   misalign_c : access crosses its natural alignment or has an invalid width
module mem_lane_align
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      width,
  input  logic            is_fetch,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [7:0]      be_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [XLEN-1:0] rdata_c,
  output logic            misalign_c
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] rshift;
  logic            sext;

  assign shamt   = {addr_lo, 3'b000};
  assign rshift  = rdata >> shamt;
  assign wdata_c = wdata << shamt;
  assign sext    = (width[2] == MEM_SIGN);

  // Byte enables; fetches always read the whole doubleword
  always_comb begin
    be_c = 8'hFF;
    if (!is_fetch) begin
      be_c = mem_be_base(width[1:0]) << addr_lo;
    end
  end

  // Load extraction/extension and alignment check
  always_comb begin
    rdata_c    = '0;
    misalign_c = 1'b0;
    case (width[1:0])
      MEM_WIDTH_BYTE: begin
        rdata_c = {{(XLEN-8){sext & rshift[7]}}, rshift[7:0]};
      end
      MEM_WIDTH_HALF: begin
        rdata_c    = {{(XLEN-16){sext & rshift[15]}}, rshift[15:0]};
        misalign_c = addr_lo[0];
      end
      MEM_WIDTH_WORD: begin
        rdata_c    = {{(XLEN-32){sext & rshift[31]}}, rshift[31:0]};
        misalign_c = |addr_lo[1:0];
      end
      default: begin
        // An unsigned doubleword has no meaning and is rejected
        rdata_c    = rshift;
        misalign_c = (|addr_lo) || (width[2] == MEM_UNSIGN);
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// Data wins over fetch unless fetch has been passed over STARVE_LIMIT times in
// a row; one access is outstanding at a time. Misaligned accesses never reach
// memory and complete one cycle after their grant with an error.
// Ports:
//   clk_in, rst_n_in : clock (rising edge), async active-low reset
//   bus              : fetch, load/store and memory signals (slave modport)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk_in,
  input logic                rst_n_in,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  localparam int unsigned      CNT_W      = 4;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  acc_ctl_t         ctl_q,    ctl_d;
  logic [2:0]       alo_q,    alo_d;

  logic              if_gnt_q,   if_gnt_d;
  logic              if_done_q,  if_done_d;
  logic              if_err_q,   if_err_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              dm_gnt_q,   dm_gnt_d;
  logic              dm_done_q,  dm_done_d;
  logic              dm_err_q,   dm_err_d;
  logic [XLEN-1:0]   dm_rdata_q, dm_rdata_d;
  logic              mem_req_q,  mem_req_d;
  logic              mem_we_q,   mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_be_q,   mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

  logic              pick_fetch_c;
  logic [ADDR_W-1:0] pick_addr_c;
  logic [2:0]        lane_alo;
  logic [2:0]        lane_width;
  logic              lane_fetch;
  logic [7:0]        lane_be;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN-1:0]   lane_rdata;
  logic              lane_misalign;

  // Winner selection: fetch only when data is absent or fetch is starved
  assign pick_fetch_c = bus.if_req_in && (!bus.dm_req_in || (starve_q == STARVE_MAX));
  assign pick_addr_c  = pick_fetch_c ? bus.if_addr_in : bus.dm_addr_in;

  // One lane aligner: it steers the incoming request while idle and the
  // latched access's read data while the access is in flight.
  always_comb begin
    lane_alo   = alo_q;
    lane_width = ctl_q.width;
    lane_fetch = ctl_q.fetch;
    if (state_q == ST_IDLE) begin
      lane_alo   = pick_addr_c[2:0];
      lane_width = pick_fetch_c ? MEM_WIDTH_FETCH : bus.dm_width_in;
      lane_fetch = pick_fetch_c;
    end
  end

  mem_lane_align #(
    .XLEN (XLEN)
  ) u_lane (
    .addr_lo    (lane_alo),
    .width      (lane_width),
    .is_fetch   (lane_fetch),
    .wdata      (bus.dm_wdata_in),
    .rdata      (bus.mem_rdata_in),
    .be_c       (lane_be),
    .wdata_c    (lane_wdata),
    .rdata_c    (lane_rdata),
    .misalign_c (lane_misalign)
  );

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    ctl_d       = ctl_q;
    alo_d       = alo_q;
    if_gnt_d    = 1'b0;
    if_done_d   = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = '0;
    dm_gnt_d    = 1'b0;
    dm_done_d   = 1'b0;
    dm_err_d    = 1'b0;
    dm_rdata_d  = '0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_be_d    = '0;
    mem_wdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (!bus.if_req_in) begin
          starve_d = '0;
        end
        if (bus.if_req_in || bus.dm_req_in) begin
          ctl_d.fetch = pick_fetch_c;
          ctl_d.we    = pick_fetch_c ? MEM_LOAD : bus.dm_we_in;
          ctl_d.width = lane_width;
          alo_d       = lane_alo;
          if (pick_fetch_c) begin
            if_gnt_d = 1'b1;
            starve_d = '0;
          end else begin
            dm_gnt_d = 1'b1;
            if (bus.if_req_in && (starve_q != '1)) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end
          if (lane_misalign) begin
            state_d = ST_ERR;
          end else begin
            state_d     = pick_fetch_c ? ST_FETCH : ST_DATA;
            mem_req_d   = 1'b1;
            mem_we_d    = ctl_d.we;
            mem_addr_d  = {pick_addr_c[ADDR_W-1:3], 3'b000};
            mem_be_d    = lane_be;
            mem_wdata_d = (ctl_d.we == MEM_STORE) ? lane_wdata : '0;
          end
        end
      end

      ST_FETCH, ST_DATA: begin
        if (bus.mem_ready_in) begin
          state_d = ST_IDLE;
          if (state_q == ST_FETCH) begin
            if_done_d  = 1'b1;
            if_rdata_d = lane_rdata[31:0];
          end else begin
            dm_done_d  = 1'b1;
            dm_rdata_d = (ctl_q.we == MEM_STORE) ? '0 : lane_rdata;
          end
        end else begin
          // Memory request stays stable until the ready cycle
          mem_req_d   = mem_req_q;
          mem_we_d    = mem_we_q;
          mem_addr_d  = mem_addr_q;
          mem_be_d    = mem_be_q;
          mem_wdata_d = mem_wdata_q;
        end
      end

      ST_ERR: begin
        state_d = ST_IDLE;
        if (ctl_q.fetch) begin
          if_done_d = 1'b1;
          if_err_d  = 1'b1;
        end else begin
          dm_done_d = 1'b1;
          dm_err_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, access context and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      ctl_q       <= '0;
      alo_q       <= '0;
      if_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_gnt_q    <= 1'b0;
      dm_done_q   <= 1'b0;
      dm_err_q    <= 1'b0;
      dm_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      ctl_q       <= ctl_d;
      alo_q       <= alo_d;
      if_gnt_q    <= if_gnt_d;
      if_done_q   <= if_done_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_gnt_q    <= dm_gnt_d;
      dm_done_q   <= dm_done_d;
      dm_err_q    <= dm_err_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.if_gnt_out    = if_gnt_q;
  assign bus.if_done_out   = if_done_q;
  assign bus.if_err_out    = if_err_q;
  assign bus.if_rdata_out  = if_rdata_q;
  assign bus.dm_gnt_out    = dm_gnt_q;
  assign bus.dm_done_out   = dm_done_q;
  assign bus.dm_err_out    = dm_err_q;
  assign bus.dm_rdata_out  = dm_rdata_q;
  assign bus.mem_req_out   = mem_req_q;
  assign bus.mem_we_out    = mem_we_q;
  assign bus.mem_addr_out  = mem_addr_q;
  assign bus.mem_be_out    = mem_be_q;
  assign bus.mem_wdata_out = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases followed by random
// fetch/load/store traffic, checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned LIMIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.XLEN(64), .ADDR_W(64)) bus ();

  mem_port_arbiter #(
    .XLEN         (64),
    .ADDR_W       (64),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: pending requests and the consecutive-pass count of fetch
  int          starve = 0;
  bit          f_pend = 0;
  logic [63:0] f_addr = '0;
  bit          d_pend = 0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [2:0]  d_width = '0;
  logic [63:0] d_wdata = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h required %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] w);
    return 1 << w[1:0];
  endfunction

  function automatic bit data_bad(input logic [63:0] a, input logic [2:0] w);
    if (w == 3'b111) return 1'b1;
    return (int'(a[2:0]) % nbytes(w)) != 0;
  endfunction

  function automatic logic [7:0] exp_be(input logic [63:0] a, input logic [2:0] w);
    logic [15:0] b;
    b = ((16'd1 << nbytes(w)) - 16'd1) << int'(a[2:0]);
    return b[7:0];
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] rd, input logic [63:0] a,
                                           input logic [2:0] w);
    int          n;
    logic [63:0] v;
    logic [63:0] m;
    n = nbytes(w);
    v = rd >> (8 * int'(a[2:0]));
    m = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    v = v & m;
    if (!w[2] && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [63:0] exp_fetch(input logic [63:0] rd, input logic [63:0] a);
    return (rd >> (32 * int'(a[2]))) & 64'hFFFF_FFFF;
  endfunction

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_flags"}, {58'b0, bus.if_gnt_out, bus.if_done_out, bus.if_err_out,
                               bus.dm_gnt_out, bus.dm_done_out, bus.dm_err_out}, 64'd0);
    check_eq({pfx, "_memctl"}, {54'b0, bus.mem_req_out, bus.mem_we_out, bus.mem_be_out}, 64'd0);
    check_eq({pfx, "_memaddr"}, bus.mem_addr_out, 64'd0);
    check_eq({pfx, "_memwdata"}, bus.mem_wdata_out, 64'd0);
    check_eq({pfx, "_dmrdata"}, bus.dm_rdata_out, 64'd0);
    check_eq({pfx, "_ifrdata"}, {32'b0, bus.if_rdata_out}, 64'd0);
  endtask

  // One arbitration round, entered and left in an idle cycle at posedge+1
  task automatic run_txn(input int lat, input logic [63:0] rd);
    bit          fw;
    bit          bad;
    logic [63:0] a;
    logic [63:0] aa;
    bus.if_req_in   = f_pend;
    bus.if_addr_in  = f_addr;
    bus.dm_req_in   = d_pend;
    bus.dm_we_in    = d_we;
    bus.dm_addr_in  = d_addr;
    bus.dm_width_in = d_width;
    bus.dm_wdata_in = d_wdata;
    if (!f_pend && !d_pend) begin
      starve = 0;
      step();
      check_eq("idle_gnt", {62'b0, bus.if_gnt_out, bus.dm_gnt_out}, 64'd0);
      return;
    end
    fw = f_pend && (!d_pend || starve == LIMIT);
    if (!f_pend || fw) starve = 0;
    else if (starve < 15) starve++;
    step();
    check_eq("if_gnt", bus.if_gnt_out, fw);
    check_eq("dm_gnt", bus.dm_gnt_out, !fw);
    if (fw) begin
      f_pend = 0;
      bus.if_req_in = 1'b0;
      a = f_addr;
      bad = (f_addr[1:0] != 2'b00);
    end else begin
      d_pend = 0;
      bus.dm_req_in = 1'b0;
      a = d_addr;
      bad = data_bad(d_addr, d_width);
    end
    aa = a & ~64'h7;
    if (bad) begin
      check_eq("err_memreq1", bus.mem_req_out, 0);
      step();
      check_eq("err_memreq2", bus.mem_req_out, 0);
      check_eq("err_done", fw ? bus.if_done_out : bus.dm_done_out, 1);
      check_eq("err_flag", fw ? bus.if_err_out : bus.dm_err_out, 1);
      check_eq("err_other_done", fw ? bus.dm_done_out : bus.if_done_out, 0);
      check_eq("err_rdata", fw ? {32'b0, bus.if_rdata_out} : bus.dm_rdata_out, 0);
    end else begin
      check_eq("mem_req", bus.mem_req_out, 1);
      check_eq("mem_addr", bus.mem_addr_out, aa);
      check_eq("mem_we", bus.mem_we_out, !fw && d_we);
      if (fw) check_eq("fetch_be", bus.mem_be_out, 8'hFF);
      else if (d_we) begin
        check_eq("st_be", bus.mem_be_out, exp_be(a, d_width));
        check_eq("st_wdata", bus.mem_wdata_out, d_wdata << (8 * int'(a[2:0])));
      end
      for (int k = 0; k < lat; k++) begin
        step();
        check_eq("wait_req", bus.mem_req_out, 1);
        check_eq("wait_addr", bus.mem_addr_out, aa);
        check_eq("wait_done", {62'b0, bus.if_done_out, bus.dm_done_out}, 0);
      end
      bus.mem_ready_in = 1'b1;
      bus.mem_rdata_in = rd;
      step();
      bus.mem_ready_in = 1'b0;
      bus.mem_rdata_in = {$urandom, $urandom};
      check_eq("done_memreq", bus.mem_req_out, 0);
      if (fw) begin
        check_eq("if_done", bus.if_done_out, 1);
        check_eq("if_err", bus.if_err_out, 0);
        check_eq("if_rdata", {32'b0, bus.if_rdata_out}, exp_fetch(rd, a));
        check_eq("if_other_done", bus.dm_done_out, 0);
      end else begin
        check_eq("dm_done", bus.dm_done_out, 1);
        check_eq("dm_err", bus.dm_err_out, 0);
        check_eq("dm_rdata", bus.dm_rdata_out, d_we ? 64'd0 : exp_load(rd, a, d_width));
        check_eq("dm_other_done", bus.if_done_out, 0);
      end
    end
  endtask

  task automatic set_data(input logic we, input logic [63:0] a, input logic [2:0] w,
                          input logic [63:0] wd);
    d_pend = 1; d_we = we; d_addr = a; d_width = w; d_wdata = wd;
  endtask

  task automatic gen_fetch();
    f_pend = 1;
    f_addr = {$urandom, $urandom};
    if ($urandom_range(0, 7) != 0) f_addr[1:0] = 2'b00;
  endtask

  task automatic gen_data();
    d_pend  = 1;
    d_we    = 1'($urandom_range(0, 1));
    d_width = 3'($urandom_range(0, 7));
    d_addr  = {$urandom, $urandom};
    d_wdata = {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0) d_addr = d_addr & ~(64'(nbytes(d_width)) - 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  initial begin
    bus.if_req_in = 1'b0; bus.if_addr_in = '0;
    bus.dm_req_in = 1'b0; bus.dm_we_in = 1'b0; bus.dm_addr_in = '0;
    bus.dm_width_in = '0; bus.dm_wdata_in = '0;
    bus.mem_ready_in = 1'b0; bus.mem_rdata_in = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed loads/stores
    set_data(1'b0, 64'h1003, 3'b000, '0);
    run_txn(0, 64'h0000_0000_80FF_0000);
    set_data(1'b0, 64'h1003, 3'b100, '0);
    run_txn(0, 64'h0000_0000_80FF_0000);
    set_data(1'b1, 64'h2006, 3'b001, 64'hBEEF);
    run_txn(0, {$urandom, $urandom});
    set_data(1'b0, 64'h3002, 3'b010, '0);
    run_txn(0, {$urandom, $urandom});
    set_data(1'b0, 64'h4008, 3'b011, '0);
    run_txn(3, 64'h0123_4567_89AB_CDEF);
    f_pend = 1; f_addr = 64'h5004;
    run_txn(2, 64'hCAFE_F00D_1234_5678);

    // Both requesters saturated: fetch wins every LIMIT+1 grants
    for (int i = 0; i < 12; i++) begin
      if (!f_pend) begin f_pend = 1; f_addr = 64'h8000 + 64'(4 * i); end
      if (!d_pend) set_data(1'b0, 64'h9000 + 64'(8 * i), 3'b011, '0);
      run_txn(0, {$urandom, $urandom});
    end

    // Reset in the middle of a data access
    f_pend = 0;
    set_data(1'b0, 64'hA000, 3'b011, '0);
    bus.if_req_in = 1'b0;
    bus.dm_req_in = 1'b1; bus.dm_we_in = 1'b0; bus.dm_addr_in = d_addr; bus.dm_width_in = d_width;
    step();
    check_eq("rst_pre_gnt", bus.dm_gnt_out, 1);
    bus.dm_req_in = 1'b0;
    d_pend = 0;
    step();
    check_eq("rst_pre_req", bus.mem_req_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    starve = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    set_data(1'b0, 64'hB005, 3'b000, '0);
    run_txn(1, 64'h0000_7F00_0000_0000);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if (!f_pend && $urandom_range(0, 2) != 0) gen_fetch();
      if (!d_pend && $urandom_range(0, 2) != 0) gen_data();
      run_txn(int'($urandom_range(0, 3)), {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
